// File: rtl/main_mem_arbiter.sv
// Arbiter sharing the single-port main data memory between the processor
// memory stage (fixed priority) and two round-robin req/ack auxiliary ports.
module main_mem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              e0_req,
  input  logic              e0_rw,
  input  logic [ADDR_W-1:0] e0_addr,
  input  logic [DATA_W-1:0] e0_wdata,
  output logic              e0_ack,
  output logic              e0_rvalid,
  output logic [DATA_W-1:0] e0_rdata,
  input  logic              e1_req,
  input  logic              e1_rw,
  input  logic [ADDR_W-1:0] e1_addr,
  input  logic [DATA_W-1:0] e1_wdata,
  output logic              e1_ack,
  output logic              e1_rvalid,
  output logic [DATA_W-1:0] e1_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_rw,
  input  logic [DATA_W-1:0] m_q
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT - 1);

  logic              last;
  logic [7:0]        wcnt;
  logic              aux_any, aux_sel, aux_gnt, cpu_gnt, aux_wait;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        rd_v;
  logic [1:0]        rd_id;

  assign cpu_q = m_q;

  always_comb begin
    aux_any  = e0_req | e1_req;
    // On a tie the port not granted most recently wins.
    aux_sel  = (e0_req & e1_req) ? ~last : e1_req;
    aux_gnt  = aux_any & (cpu_stall | ~cpu_en);
    cpu_gnt  = cpu_en & ~cpu_stall;
    aux_wait = aux_any & ~aux_gnt;
    e0_ack   = aux_gnt & ~aux_sel;
    e1_ack   = aux_gnt & aux_sel;
    sel_rw   = aux_sel ? e1_rw    : e0_rw;
    sel_addr = aux_sel ? e1_addr  : e0_addr;
    sel_data = aux_sel ? e1_wdata : e0_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_addr <= '0;
      m_data <= '0;
      m_rw   <= 1'b0;
    end else if (cpu_gnt) begin
      m_addr <= cpu_addr;
      m_data <= cpu_data;
      m_rw   <= cpu_rw;
    end else if (aux_gnt) begin
      m_addr <= sel_addr;
      m_data <= sel_data;
      m_rw   <= sel_rw;
    end else begin
      m_rw   <= 1'b0;
    end
  end

  // Two-stage valid/ID pipe follows the read through the memory latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_v      <= '0;
      rd_id     <= '0;
      e0_rvalid <= 1'b0;
      e1_rvalid <= 1'b0;
      e0_rdata  <= '0;
      e1_rdata  <= '0;
    end else begin
      rd_v[0]   <= aux_gnt & ~sel_rw;
      rd_id[0]  <= aux_sel;
      rd_v[1]   <= rd_v[0];
      rd_id[1]  <= rd_id[0];
      e0_rvalid <= rd_v[1] & ~rd_id[1];
      e1_rvalid <= rd_v[1] & rd_id[1];
      if (rd_v[1] & ~rd_id[1]) e0_rdata <= m_q;
      if (rd_v[1] & rd_id[1])  e1_rdata <= m_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last      <= 1'b1;
      wcnt      <= '0;
      cpu_stall <= 1'b0;
    end else begin
      cpu_stall <= 1'b0;
      if (aux_gnt) begin
        last <= aux_sel;
        wcnt <= '0;
      end else if (aux_wait) begin
        // A stall cycle always grants any pending request, so this
        // branch cannot fire twice in a row.
        if (wcnt == WAIT_MAX) begin
          cpu_stall <= 1'b1;
          wcnt      <= '0;
        end else if (wcnt < WAIT_MAX) begin
          wcnt <= wcnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter: memory macro model, a
// transaction-level reference model, directed scenarios and random traffic.
module tb_main_mem_arbiter;

  localparam int MW = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_en = 1'b0, cpu_rw = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [15:0] cpu_data = '0;
  logic [15:0] cpu_q;
  logic        cpu_stall;
  logic        e0_req = 1'b0, e0_rw = 1'b0, e1_req = 1'b0, e1_rw = 1'b0;
  logic [11:0] e0_addr = '0, e1_addr = '0;
  logic [15:0] e0_wdata = '0, e1_wdata = '0;
  logic        e0_ack, e0_rvalid, e1_ack, e1_rvalid;
  logic [15:0] e0_rdata, e1_rdata;
  logic [11:0] m_addr;
  logic [15:0] m_data;
  logic        m_rw;
  logic [15:0] m_q;

  int tests = 0;
  int fails = 0;

  main_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .e0_req(e0_req), .e0_rw(e0_rw), .e0_addr(e0_addr), .e0_wdata(e0_wdata),
    .e0_ack(e0_ack), .e0_rvalid(e0_rvalid), .e0_rdata(e0_rdata),
    .e1_req(e1_req), .e1_rw(e1_rw), .e1_addr(e1_addr), .e1_wdata(e1_wdata),
    .e1_ack(e1_ack), .e1_rvalid(e1_rvalid), .e1_rdata(e1_rdata),
    .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_q(m_q)
  );

  always #5 clock = ~clock;

  // Memory macro: synchronous write, read data one cycle after address.
  logic [15:0] mem [4096];
  always @(posedge clock) begin
    if (m_rw) mem[m_addr] <= m_data;
    m_q <= mem[m_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int port; logic [15:0] data; } ret_t;
  ret_t        rq[$];
  logic [15:0] xmem [4096];
  logic [11:0] x_maddr;
  logic [15:0] x_mdata;
  bit          x_mrw, x_stall;
  int          last_port, waited, cyc;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = 16'(i) ^ 16'h5A5A;
      xmem[i] = 16'(i) ^ 16'h5A5A;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      rq.delete();
      x_maddr = '0; x_mdata = '0; x_mrw = 0; x_stall = 0;
      last_port = 1; waited = 0; cyc = 0;
      chk("rst_m_rw", m_rw, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_rvalid", {e0_rvalid, e1_rvalid}, 0);
    end else begin
      bit ev0, ev1, want0, want1;
      logic [15:0] ed0, ed1;
      int pick, winner;
      chk("m_addr", m_addr, x_maddr);
      chk("m_data", m_data, x_mdata);
      chk("m_rw", m_rw, x_mrw);
      chk("cpu_stall", cpu_stall, x_stall);
      if (x_mrw) xmem[x_maddr] = x_mdata;
      ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
      while (rq.size() > 0 && rq[0].due <= cyc) begin
        if (rq[0].port == 2) chk("cpu_q", cpu_q, rq[0].data);
        else if (rq[0].port == 0) begin ev0 = 1; ed0 = rq[0].data; end
        else begin ev1 = 1; ed1 = rq[0].data; end
        void'(rq.pop_front());
      end
      chk("e0_rvalid", e0_rvalid, ev0);
      chk("e1_rvalid", e1_rvalid, ev1);
      if (ev0) chk("e0_rdata", e0_rdata, ed0);
      if (ev1) chk("e1_rdata", e1_rdata, ed1);
      // who owns this cycle
      want0 = e0_req; want1 = e1_req;
      if (want0 && want1) pick = (last_port == 1) ? 0 : 1;
      else pick = want1 ? 1 : 0;
      if (x_stall) winner = (want0 || want1) ? pick : -1;
      else if (cpu_en) winner = 2;
      else if (want0 || want1) winner = pick;
      else winner = -1;
      chk("e0_ack", e0_ack, winner == 0);
      chk("e1_ack", e1_ack, winner == 1);
      x_mrw = 0;
      if (winner == 2) begin
        x_maddr = cpu_addr; x_mdata = cpu_data; x_mrw = cpu_rw;
        if (!cpu_rw) rq.push_back('{cyc + 2, 2, xmem[cpu_addr]});
      end else if (winner == 0) begin
        x_maddr = e0_addr; x_mdata = e0_wdata; x_mrw = e0_rw;
        if (!e0_rw) rq.push_back('{cyc + 3, 0, xmem[e0_addr]});
      end else if (winner == 1) begin
        x_maddr = e1_addr; x_mdata = e1_wdata; x_mrw = e1_rw;
        if (!e1_rw) rq.push_back('{cyc + 3, 1, xmem[e1_addr]});
      end
      x_stall = 0;
      if (winner == 0 || winner == 1) begin
        last_port = winner; waited = 0;
      end else if (want0 || want1) begin
        if (waited == MW - 1) begin x_stall = 1; waited = 0; end
        else waited++;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    cpu_en = 0; cpu_rw = 0; e0_req = 0; e0_rw = 0; e1_req = 0; e1_rw = 0;
  endtask

  // Leaves the caller at the start of cycle 0 after reset.
  task automatic do_reset();
    step(); reset = 1; idle_inputs();
    step(); step(); reset = 0;
  endtask

  initial begin
    bit p0, p1;
    do_reset();
    @(negedge clock);
    chk("reset_m_addr", m_addr, 12'h000);
    chk("reset_e0_rdata", e0_rdata, 16'h0000);

    // CPU write then read back
    step(); cpu_en = 1; cpu_rw = 1; cpu_addr = 12'h010; cpu_data = 16'h1234;
    @(negedge clock);
    step(); cpu_rw = 0;
    @(negedge clock);
    chk("cpu_wr_m_rw", m_rw, 1);
    chk("cpu_wr_m_addr", m_addr, 12'h010);
    step(); cpu_en = 0;
    @(negedge clock); chk("cpu_stall_0", cpu_stall, 0);
    step(); @(negedge clock);
    chk("cpu_rd_q", cpu_q, 16'h1234);

    // preload 0x020 then single e0 read
    step(); cpu_en = 1; cpu_rw = 1; cpu_addr = 12'h020; cpu_data = 16'hBEEF;
    step(); cpu_en = 0; e0_req = 1; e0_rw = 0; e0_addr = 12'h020;
    @(negedge clock); chk("e0_ack_same_cycle", e0_ack, 1);
    for (int k = 1; k <= 4; k++) begin
      step(); e0_req = 0;
      @(negedge clock);
      chk("e0_rvalid_lat", e0_rvalid, k == 3);
      if (k == 3) chk("e0_rdata_beef", e0_rdata, 16'hBEEF);
    end

    // both aux ports requesting continuously
    do_reset();
    e0_req = 1; e0_addr = 12'h100; e1_req = 1; e1_addr = 12'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("rr_e0", e0_ack, (i % 2) == 0);
      chk("rr_e1", e1_ack, (i % 2) == 1);
      p0 = e0_ack; p1 = e1_ack;
      step();
      if (p0) e0_addr = e0_addr + 12'd1;
      if (p1) e1_addr = e1_addr + 12'd1;
    end
    idle_inputs();
    repeat (4) @(negedge clock);

    // starvation bound with cpu_en held high
    do_reset();
    cpu_en = 1; cpu_rw = 0; cpu_addr = 12'h055;
    e1_req = 1; e1_rw = 0; e1_addr = 12'h066;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clock);
      chk("starve_stall", cpu_stall, k == 8);
      chk("starve_e1_ack", e1_ack, k == 8);
      if (k == 9)  chk("starve_m_addr_e1", m_addr, 12'h066);
      if (k == 10) chk("starve_m_addr_cpu", m_addr, 12'h055);
      p1 = e1_ack;
      step();
      if (p1) e1_req = 0;
    end
    idle_inputs();

    // reset one cycle after an e0 read grant
    do_reset();
    e0_req = 1; e0_rw = 0; e0_addr = 12'h020;
    @(negedge clock); chk("rst_mid_ack", e0_ack, 1);
    step(); e0_req = 0; reset = 1;
    @(negedge clock);
    chk("rst_mid_m_addr", m_addr, 12'h000);
    chk("rst_mid_rvalid", e0_rvalid, 0);
    step(); step(); reset = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock); chk("rst_mid_no_rvalid", e0_rvalid, 0);
      step();
    end

    // mixed traffic to 0x3FF
    do_reset();
    cpu_en = 1; cpu_rw = 1; cpu_addr = 12'h3FF; cpu_data = 16'h1111;
    e0_req = 1; e0_rw = 1; e0_addr = 12'h3FF; e0_wdata = 16'h2222;
    e1_req = 1; e1_rw = 0; e1_addr = 12'h3FF;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) chk("mix_e0_ack", e0_ack, 1);
      if (k == 2) chk("mix_e1_ack", e1_ack, 1);
      if (k == 5) begin
        chk("mix_e1_rvalid", e1_rvalid, 1);
        chk("mix_e1_rdata", e1_rdata, 16'h2222);
        chk("mix_cpu_q", cpu_q, 16'h2222);
      end
      step();
      case (k)
        0: cpu_en = 0;
        1: e0_req = 0;
        2: begin e1_req = 0; cpu_en = 1; cpu_rw = 0; end
        3: cpu_en = 0;
        default: ;
      endcase
    end

    // random traffic against the model
    idle_inputs();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      p0 = e0_ack; p1 = e1_ack;
      step();
      if ($urandom_range(0, 399) == 0) begin
        reset = 1; idle_inputs();
        step(); reset = 0;
        continue;
      end
      cpu_en = ($urandom_range(0, 2) == 0); cpu_rw = $urandom_range(0, 1);
      cpu_addr = 12'($urandom_range(0, 15)); cpu_data = 16'($urandom);
      if (!e0_req || p0) begin
        e0_req = ($urandom_range(0, 2) != 0); e0_rw = $urandom_range(0, 1);
        e0_addr = 12'($urandom_range(0, 15)); e0_wdata = 16'($urandom);
      end
      if (!e1_req || p1) begin
        e1_req = ($urandom_range(0, 2) != 0); e1_rw = $urandom_range(0, 1);
        e1_addr = 12'($urandom_range(0, 15)); e1_wdata = 16'($urandom);
      end
      if (n % 500 < 100) cpu_en = 1;
    end
    idle_inputs();
    repeat (5) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Shares the single-port main data memory (12-bit address, 16-bit data, write-enable `rw`, read data one cycle after address) between the processor's memory stage and two auxiliary requesters, e.g. a program loader and a debug/inspection port. The processor has fixed priority and needs no handshake. The two auxiliary ports use req/ack handshakes with round-robin arbitration between them. A wait counter forces a one-cycle processor stall so that the auxiliary ports cannot starve. The block sits between the processor's `main_m_*` signals and the memory macro.

## Interface
- `ADDR_W`, default 12: memory address width.
- `DATA_W`, default 16: memory data width.
- `MAX_WAIT`, default 8 (legal range 2..255): consecutive ungranted auxiliary-request cycles before a forced stall.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_en`  in  1  processor requests a memory access this cycle.
- `cpu_rw`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  processor address.
- `cpu_data`  in  DATA_W  processor write data.
- `cpu_q`  out  DATA_W  combinational pass-through of `m_q`.
- `cpu_stall`  out  1  registered; while high the processor access is not performed and must be re-presented.
- `eN_req` (N = 0, 1)  in  1  auxiliary request; held, with rw/addr/wdata stable, until ack.
- `eN_rw`, `eN_addr`, `eN_wdata`  in  1 / ADDR_W / DATA_W  auxiliary access fields.
- `eN_ack`  out  1  combinational; high in the cycle the request is granted.
- `eN_rvalid`  out  1  registered; one-cycle pulse carrying read data.
- `eN_rdata`  out  DATA_W  registered read data, valid while `eN_rvalid` is high.
- `m_addr`, `m_data`, `m_rw`  out  ADDR_W / DATA_W / 1  registered memory controls.
- `m_q`  in  DATA_W  memory read data, valid in the cycle after `m_addr` is presented.

## Operation
- Grant rule in cycle t, with priority in this order:
  1. If `cpu_stall` is high, grant the auxiliary port selected by round-robin and ignore `cpu_en`.
  2. Otherwise, if `cpu_en` is high, grant the processor.
  3. Otherwise, if any `eN_req` is high, grant by round-robin.
  4. Otherwise the cycle is idle.
- Round-robin pointer `last`:
  - When both auxiliary ports request, grant the port that was not granted most recently.
  - When only one requests, grant that one.
  - Update `last` on every auxiliary grant.
- Memory update at the edge ending cycle t:
  - Granted port: `m_addr`, `m_data` and `m_rw` take that port's fields.
  - Idle cycle: `m_rw <= 0`; `m_addr` and `m_data` hold their values.
- Auxiliary read granted in cycle t: `m_q` is captured into `eN_rdata` at the edge ending t+2, and `eN_rvalid` is high in cycle t+3. Auxiliary writes produce an ack only, with no rvalid.
- Returned reads track port ID through a 2-stage valid/ID shift register, so back-to-back and interleaved reads return in issue order.
- Wait counter `wcnt`:
  - Increments in each cycle where an `eN_req` is high and no auxiliary port is granted.
  - Clears on any auxiliary grant.
  - Saturates at `MAX_WAIT-1`.
  - If `wcnt == MAX_WAIT-1` and an auxiliary request is still ungranted, then `cpu_stall <= 1` for exactly the next cycle and `wcnt <= 0`.
- `cpu_stall` is never high for two consecutive cycles.
- Reset values: `m_addr` = 0, `m_data` = 0, `m_rw` = 0, `cpu_stall` = 0, `eN_rvalid` = 0, `eN_rdata` = 0, `last` = 1 (so e0 wins the first tie), `wcnt` = 0, return pipeline empty.
- Reset mid-operation discards all in-flight reads; no rvalid is produced for them.
- If a requester drops `eN_req` during a stall cycle (a protocol violation), the stall cycle becomes idle: `m_rw = 0`, no ack.

## Timing
- Processor access: request in cycle t; `m_*` valid in t+1; read data on `cpu_q` in t+2. The processor sees no added latency compared with a direct connection.
- Auxiliary access latency:
  - Ack in the same cycle as the grant.
  - Read data `eN_rvalid` 3 cycles after the grant.
  - Minimum request-to-data time 3 cycles when uncontended.
- Throughput: one access per cycle, every cycle.
- Starvation bound: with `cpu_en` held high, an auxiliary request is acked no later than cycle MAX_WAIT after it is first asserted, i.e. in the stall cycle.
- Idle-to-busy: a request arriving in an idle cycle is granted in that same cycle (no bubble).
- `cpu_q` has no register stage; the `m_q` to `cpu_q` path is combinational.

## Test plan
- Reset then processor-only traffic: CPU writes 0x1234 to address 0x010 in cycle 1 and reads 0x010 in cycle 2. Required: `m_rw` = 1 in cycle 2, `cpu_q` = 0x1234 in cycle 4, `cpu_stall` stays 0.
- Single auxiliary read with CPU idle: e0 reads 0x020, which was preloaded with 0xBEEF. Required: `e0_ack` in the request cycle, `e0_rvalid` = 1 with `e0_rdata` = 0xBEEF exactly 3 cycles later, one pulse only.
- Both auxiliary ports request continuously, CPU idle. Required: acks alternate e0, e1, e0, … with e0 first after reset; rdata for each read returns to the correct port, in order.
- `cpu_en` held high with `MAX_WAIT` = 8 while e1 requests from cycle 0. Required: `cpu_stall` is high in cycle 8 only, `e1_ack` in cycle 8, and the processor address reappears on `m_addr` in cycle 10.
- Reset asserted one cycle after an e0 read grant. Required: all outputs reset immediately, and no `e0_rvalid` is produced afterward.
- Mixed traffic: CPU write, e0 write, e1 read, all to address 0x3FF, then read back. Required: the memory holds the value of the last granted write, and the e1 read returns the value present at its own grant time.
